// File: rtl/stc_pkg.sv
// stc_pkg: shared types and defaults for the stc B-side scheduler and distribution network
package stc_pkg;

    localparam int K_DEF    = 16;
    localparam int N_PE_DEF = 4;

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/stc_lowbit_pick.sv
// stc_lowbit_pick: picks the N_PE lowest set-bit indices of a vector and returns what is left
module stc_lowbit_pick #(
    parameter int K      = 16,
    parameter int DW_COL = 4,
    parameter int N_PE   = 4
) (
    input  logic [K-1:0]           vec,
    output logic [N_PE*DW_COL-1:0] cols,
    output logic [N_PE-1:0]        vld,
    output logic [K-1:0]           rest
);

    // peel the lowest set bit once per lane so indices ascend with lane number
    always_comb begin
        logic [K-1:0] v;
        v    = vec;
        cols = '0;
        vld  = '0;
        for (int j = 0; j < N_PE; j++) begin
            vld[j] = |v;
            for (int i = K - 1; i >= 0; i--)
                if (v[i]) cols[j*DW_COL +: DW_COL] = DW_COL'(i);
            v = v & (v - K'(1));
        end
        rest = v;
    end

endmodule

// File: rtl/stc_b_dn_sched.sv
// stc_b_dn_sched: compacts a nonzero-column mask into ascending index beats for stc_B_DN
module stc_b_dn_sched
    import stc_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int DW_COL = clog2(K),
    parameter int N_PE   = N_PE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K-1:0]           in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_PE*DW_COL-1:0] out_cols,
    output logic [N_PE-1:0]        out_lane_vld,
    output logic                   out_last,
    output logic [DW_COL-1:0]      out_beat,
    output logic                   busy
);

    state_t              state, state_nx;
    logic [K-1:0]        rem, rem_nx, rest;
    logic [DW_COL-1:0]   beat, beat_nx;
    logic                live;

    stc_lowbit_pick #(.K(K), .DW_COL(DW_COL), .N_PE(N_PE)) u_pick (
        .vec  (rem),
        .cols (out_cols),
        .vld  (out_lane_vld),
        .rest (rest)
    );

    // nothing left after this beat's picks means this is the final beat
    assign busy      = state == ISSUE;
    assign out_valid = busy;
    assign out_last  = busy && rest == '0;
    assign out_beat  = beat;
    assign in_ready  = live && (!busy || (out_last && out_ready));

    // next mask load, beat advance, or drop back to idle
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        beat_nx  = beat;
        if (in_valid && in_ready) begin
            state_nx = ISSUE;
            rem_nx   = in_mask;
            beat_nx  = '0;
        end else if (busy && out_ready) begin
            state_nx = out_last ? IDLE : ISSUE;
            rem_nx   = out_last ? '0 : rest;
            beat_nx  = out_last ? '0 : beat + 1'b1;
        end
    end

    // state registers; live keeps in_ready low until the first edge after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rem   <= '0;
            beat  <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            beat  <= beat_nx;
            live  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stc_b_dn_sched.sv
// tb_stc_b_dn_sched: randomized and directed checks of the column scheduler against a beat-list model
module tb_stc_b_dn_sched;

    localparam int K  = 16;
    localparam int DW = 4;
    localparam int NP = 4;

    typedef struct packed {
        logic [NP*DW-1:0] cols;
        logic [NP-1:0]    vld;
        logic             last;
        logic [DW-1:0]    beat;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [K-1:0]     in_mask = '0;
    logic             in_ready, out_valid, out_last, busy;
    logic [NP*DW-1:0] out_cols;
    logic [NP-1:0]    out_lane_vld;
    logic [DW-1:0]    out_beat;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    stc_b_dn_sched #(.K(K), .DW_COL(DW), .N_PE(NP)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mask      (in_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cols     (out_cols),
        .out_lane_vld (out_lane_vld),
        .out_last     (out_last),
        .out_beat     (out_beat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected beats: ascending set-bit list cut into groups of NP, at least one beat
    task automatic push_mask(input logic [K-1:0] m);
        int    idx[$];
        beat_t b;
        for (int i = 0; i < K; i++) if (m[i]) idx.push_back(i);
        for (int n = 0; n == 0 || n * NP < idx.size(); n++) begin
            b = '0;
            for (int j = 0; j < NP; j++)
                if (n * NP + j < idx.size()) begin
                    b.cols[j*DW +: DW] = DW'(idx[n*NP+j]);
                    b.vld[j] = 1'b1;
                end
            b.beat = DW'(n);
            b.last = (n + 1) * NP >= idx.size();
            exp_q.push_back(b);
        end
    endtask

    task automatic step(input logic iv, input logic [K-1:0] m, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        in_mask   = m;
        out_ready = ordy;
        #1;
        check("out_valid", out_valid, exp_q.size() > 0);
        check("busy", busy, exp_q.size() > 0);
        check("in_ready", in_ready, exp_q.size() == 0 ? 1'b1 : (exp_q[0].last && ordy));
        if (exp_q.size() > 0) begin
            check("out_cols", out_cols, exp_q[0].cols);
            check("out_lane_vld", out_lane_vld, exp_q[0].vld);
            check("out_last", out_last, exp_q[0].last);
            check("out_beat", out_beat, exp_q[0].beat);
        end
        acc = in_valid && in_ready;
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) push_mask(m);
    endtask

    task automatic drain(input int pct);
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step(1'b0, '0, $urandom_range(0, 99) < pct, acc);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        step(1'b0, '0, 1'b1, acc);
    endtask

    task automatic send(input logic [K-1:0] m, input int pct);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            step(1'b1, m, $urandom_range(0, 99) < pct, acc);
            n++;
        end
        check("accept_timeout", acc, 1'b1);
        drain(pct);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cols", out_cols, 0);
        check("rst_out_lane_vld", out_lane_vld, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_beat", out_beat, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        logic           acc;
        logic [K-1:0]   m;
        logic [15:0]    dir[6] = '{16'h000F, 16'h00FF, 16'h0013, 16'h8421, 16'h0000, 16'h0003};
        int             c;
        #1;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        foreach (dir[i]) send(dir[i], 100);
        // full mask with stalls, second mask held until the last-beat handshake
        send(16'h0000, 100);
        acc = 1'b0;
        while (!acc) step(1'b1, 16'hFFFF, 1'b1, acc);
        c = 0;
        acc = 1'b0;
        while (!acc && c < 100) begin
            step(1'b1, 16'h0001, (c % 3) == 2, acc);
            c++;
        end
        check("b2b_accept", acc, 1'b1);
        drain(100);
        // reset mid-group
        acc = 1'b0;
        while (!acc) step(1'b1, 16'hFFFF, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        send(16'h0003, 100);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = K'(1) << $urandom_range(0, K - 1);
                2: m = K'($urandom) & K'($urandom);
                default: m = K'($urandom);
            endcase
            step($urandom_range(0, 1) == 1, m, $urandom_range(0, 3) != 0, acc);
        end
        drain(100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
